q78_multiplier: RTL and testbench

- Iterative signed Q7.8 x Q7.8 multiplier; the multiplicative counterpart of the datapath's combinational Q7.8 divider.
- Produces a saturated, rounded Q7.8 result plus an overflow flag.
- Sits in the processor execute stage as a multi-cycle functional unit with valid/ready handshakes on input and output.
- Radix-2 shift-add on operand magnitudes, one multiplier bit per cycle.

---
 rtl/q78_multiplier.sv | 140 ++++++++++++++
 tb/tb_q78_multiplier.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/q78_multiplier.sv
// Iterative signed Q7.8 multiplier: radix-2 shift-add on operand magnitudes,
// one multiplier bit per cycle, followed by a round/saturate step back to Q7.8.
module q78_multiplier #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] op_a,
    input  logic signed [WIDTH-1:0] op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [PW-1:0]    RND      = PW'(1) << (FRAC - 1);
    localparam logic [PW-1:0]    MAX_POS  = PW'((1 << (WIDTH - 1)) - 1);
    localparam logic [PW-1:0]    MAX_NEG  = PW'(1 << (WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             sign;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             accept;
    logic [WIDTH:0]   rs;

    // Round half away from zero on the magnitude, then clamp to the signed range.
    // Packs {overflow, result}; a zero magnitude never produces negative zero.
    function automatic logic [WIDTH:0] round_sat(input logic [PW-1:0] p, input logic neg);
        logic [PW-1:0]    r;
        logic [WIDTH-1:0] mag;
        logic [WIDTH-1:0] res;
        r   = (p + RND) >> FRAC;
        mag = r[WIDTH-1:0];
        if (!neg && (r > MAX_POS)) begin
            return {1'b1, MAX_POS[WIDTH-1:0]};
        end
        if (neg && (r > MAX_NEG)) begin
            return {1'b1, MAX_NEG[WIDTH-1:0]};
        end
        res = neg ? (WIDTH'(0) - mag) : mag;
        return {1'b0, res};
    endfunction

    // |-2^(WIDTH-1)| wraps to the same bit pattern, which is the correct unsigned magnitude.
    assign mag_a  = op_a[WIDTH-1] ? $unsigned(-op_a) : $unsigned(op_a);
    assign mag_b  = op_b[WIDTH-1] ? $unsigned(-op_b) : $unsigned(op_b);
    assign accept = (state_q == IDLE) && in_valid;
    assign rs     = round_sat(acc, sign);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iterations, registered rounded result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                sign   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                mcand  <= PW'(mag_a);
                mplier <= mag_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state_q == CALC) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end else if (state_q == FINISH) begin
                result   <= $signed(rs[WIDTH-1:0]);
                overflow <= rs[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_q78_multiplier.sv
// Directed bench for q78_multiplier: reset, rounding, saturation,
// back-pressure and reset-abort scenarios with hand-computed expectations.
module tb_q78_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    q78_multiplier #(.WIDTH(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operand pair, measure latency to out_valid, check the result.
    // With out_ready high the handshake follows and in_ready must return.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic eo);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = 16'h7FFF;
        op_b     = 16'h7FFF;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd17);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
            check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int highs;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;

        // Asynchronous reset asserted between clock edges.
        #22;
        rst_n = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'h0000);
        check("rst overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 16'h0180, 16'h0200, 16'h0300, 1'b0);
        run_op("neg", 16'hFE80, 16'h0200, 16'hFD00, 1'b0);
        run_op("half_pos", 16'h0001, 16'h0080, 16'h0001, 1'b0);
        run_op("half_neg", 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0);
        run_op("zero", 16'h0000, 16'h8000, 16'h0000, 1'b0);
        run_op("sat_pos", 16'h6400, 16'h0200, 16'h7FFF, 1'b1);
        run_op("min_min", 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
        run_op("min_one", 16'h8000, 16'h0100, 16'h8000, 1'b0);
        run_op("sat_neg", 16'h9C00, 16'h0200, 16'h8000, 1'b1);

        // Back-pressure: result held while new operands are offered.
        out_ready = 1'b0;
        run_op("bp", 16'h0180, 16'h0200, 16'h0300, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            op_a     = 16'h0100 + 16'(i);
            op_b     = 16'h0300;
            @(posedge clk);
            #1;
            check("bp result", 32'(result), 32'h0300);
            check("bp overflow", 32'(overflow), 32'd0);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);

        // Reset during CALC with counter at 7 aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 16'h6400;
        op_b     = 16'h0200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst result", 32'(result), 32'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) highs++;
        end
        check("midrst stale valid", 32'(highs), 32'd0);
        run_op("after_rst", 16'h0100, 16'h0100, 16'h0100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
